// File: rtl/aes_enc_ctrl_pkg.sv
// Shared constants, FSM encoding and GF(2^8) helpers for the AES-128 encryption controller.
package aes_enc_ctrl_pkg;

    localparam int unsigned NR = 10;
    localparam int unsigned RW = 4;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } ctrl_state_e;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] p;
        acc = 8'h00;
        p   = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ p;
            p = xtime(p);
        end
        return acc;
    endfunction

    // Inverse computed as x^254, which also maps 0 to 0 as the S-box needs.
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] r;
        logic [7:0] p;
        r = 8'h01;
        p = x;
        for (int i = 1; i < 8; i++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] b;
        b = gf_inv(x);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]}
               ^ 8'h63;
    endfunction

    function automatic logic [7:0] rcon(input logic [RW-1:0] round);
        logic [7:0] rc;
        case (round)
            4'd1:    rc = 8'h01;
            4'd2:    rc = 8'h02;
            4'd3:    rc = 8'h04;
            4'd4:    rc = 8'h08;
            4'd5:    rc = 8'h10;
            4'd6:    rc = 8'h20;
            4'd7:    rc = 8'h40;
            4'd8:    rc = 8'h80;
            4'd9:    rc = 8'h1b;
            4'd10:   rc = 8'h36;
            default: rc = 8'h00;
        endcase
        return rc;
    endfunction

endpackage

// File: rtl/aes_enc_ctrl_key_gen.sv
// AES-128 key schedule step: derives round key 'round' from the previous round key.
module aes_enc_ctrl_key_gen
    import aes_enc_ctrl_pkg::*;
(
    input  logic [RW-1:0] round,
    input  logic [127:0]  key_in,
    output logic [127:0]  key_out
);

    logic [31:0] w0, w1, w2, w3;
    logic [31:0] n0, n1, n2, n3;
    logic [31:0] temp;

    assign w0 = key_in[127:96];
    assign w1 = key_in[95:64];
    assign w2 = key_in[63:32];
    assign w3 = key_in[31:0];

    // RotWord folded into the byte order of the SubWord lookup.
    assign temp = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])}
                  ^ {rcon(round), 24'h000000};

    assign n0 = w0 ^ temp;
    assign n1 = w1 ^ n0;
    assign n2 = w2 ^ n1;
    assign n3 = w3 ^ n2;

    assign key_out = {n0, n1, n2, n3};

endmodule

// File: rtl/aes_enc_ctrl.sv
// Iterative AES-128 encryption sequencer: initial AddRoundKey, then one shared-datapath round
// per clock, with the ciphertext presented over a valid/ready handshake.
module aes_enc_ctrl
    import aes_enc_ctrl_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [127:0]  data_in,
    input  logic [127:0]  key_in,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [127:0]  data_out,
    output logic          busy,
    output logic [RW-1:0] dp_round_num,
    output logic [127:0]  dp_data,
    output logic [127:0]  dp_key,
    output logic          dp_last,
    input  logic [127:0]  dp_result
);

    ctrl_state_e   state_q, state_d;
    logic [RW-1:0] round_cnt_q, round_cnt_d;
    logic [127:0]  state_reg_q, state_reg_d;
    logic [127:0]  key_reg_q, key_reg_d;
    logic [127:0]  key_next;
    logic          accept;
    logic          last_round;

    aes_enc_ctrl_key_gen u_key_gen (
        .round   (round_cnt_q),
        .key_in  (key_reg_q),
        .key_out (key_next)
    );

    assign last_round = (round_cnt_q == RW'(NR));

    // DONE with out_ready lets a new block in on the same edge the result leaves.
    assign in_ready     = (state_q == StIdle) || ((state_q == StDone) && out_ready);
    assign accept       = in_valid && in_ready;
    assign out_valid    = (state_q == StDone);
    assign busy         = (state_q == StRun);
    assign data_out     = out_valid ? state_reg_q : 128'h0;
    assign dp_round_num = busy ? round_cnt_q : '0;
    assign dp_data      = state_reg_q;
    assign dp_key       = key_reg_q;
    assign dp_last      = busy && last_round;

    always_comb begin
        state_d     = state_q;
        round_cnt_d = round_cnt_q;
        state_reg_d = state_reg_q;
        key_reg_d   = key_reg_q;

        case (state_q)
            StIdle: ;
            StRun: begin
                state_reg_d = dp_result;
                key_reg_d   = key_next;
                if (last_round) begin
                    state_d     = StDone;
                    round_cnt_d = '0;
                end else begin
                    round_cnt_d = round_cnt_q + RW'(1);
                end
            end
            StDone: begin
                if (out_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        if (accept) begin
            state_reg_d = data_in ^ key_in;
            key_reg_d   = key_in;
            round_cnt_d = RW'(1);
            state_d     = StRun;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            round_cnt_q <= '0;
            state_reg_q <= '0;
            key_reg_q   <= '0;
        end else begin
            state_q     <= state_d;
            round_cnt_q <= round_cnt_d;
            state_reg_q <= state_reg_d;
            key_reg_q   <= key_reg_d;
        end
    end

endmodule

// File: tb/tb_aes_enc_ctrl.sv
// Bench for aes_enc_ctrl: supplies the round datapath from a byte-level AES model and checks
// ciphertexts, handshake timing and round sequencing against an independent reference.
`timescale 1ns/1ps
module tb_aes_enc_ctrl;

    localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    localparam logic [2047:0] SBOX_HEX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic [127:0]  data_in = '0;
    logic [127:0]  key_in = '0;
    logic          in_ready, out_valid, busy, dp_last;
    logic [127:0]  data_out, dp_data, dp_key, dp_result;
    logic [3:0]    dp_round_num;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] sb(input logic [7:0] x);
        logic [2047:0] t;
        t = SBOX_HEX;
        return t[2047 - 8 * int'(x) -: 8];
    endfunction

    function automatic logic [7:0] xt(input logic [7:0] a);
        return (a << 1) ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [127:0] next_key(input logic [127:0] k, input int rnd);
        logic [7:0]  rc;
        logic [31:0] w[4];
        logic [31:0] t;
        rc = 8'h01;
        for (int i = 1; i < rnd; i++) rc = xt(rc);
        for (int i = 0; i < 4; i++) w[i] = k[127 - 32 * i -: 32];
        t = {sb(w[3][23:16]), sb(w[3][15:8]), sb(w[3][7:0]), sb(w[3][31:24])} ^ {rc, 24'h0};
        w[0] = w[0] ^ t;
        for (int i = 1; i < 4; i++) w[i] = w[i] ^ w[i - 1];
        return {w[0], w[1], w[2], w[3]};
    endfunction

    function automatic logic [127:0] tb_round(input logic [127:0] d, input logic [127:0] k,
                                              input int rnd, input bit last);
        logic [7:0]   s[16];
        logic [7:0]   t[16];
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] r;
        for (int i = 0; i < 16; i++) s[i] = sb(d[127 - 8 * i -: 8]);
        for (int c = 0; c < 4; c++)
            for (int w = 0; w < 4; w++) t[w + 4 * c] = s[w + 4 * ((c + w) % 4)];
        if (!last) begin
            for (int c = 0; c < 4; c++) begin
                a0 = t[4 * c]; a1 = t[4 * c + 1]; a2 = t[4 * c + 2]; a3 = t[4 * c + 3];
                t[4 * c]     = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
                t[4 * c + 1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
                t[4 * c + 2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
                t[4 * c + 3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
            end
        end
        for (int i = 0; i < 16; i++) r[127 - 8 * i -: 8] = t[i];
        return r ^ next_key(k, rnd);
    endfunction

    function automatic logic [127:0] ref_encrypt(input logic [127:0] pt, input logic [127:0] key);
        logic [127:0] s;
        logic [127:0] k;
        s = pt ^ key;
        k = key;
        for (int r = 1; r <= 10; r++) begin
            s = tb_round(s, k, r, r == 10);
            k = next_key(k, r);
        end
        return s;
    endfunction

    assign dp_result = tb_round(dp_data, dp_key, int'(dp_round_num), dp_last);

    aes_enc_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .data_in      (data_in),
        .key_in       (key_in),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .data_out     (data_out),
        .busy         (busy),
        .dp_round_num (dp_round_num),
        .dp_data      (dp_data),
        .dp_key       (dp_key),
        .dp_last      (dp_last),
        .dp_result    (dp_result)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!out_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("wait_out_valid", out_valid, 1);
    endtask

    // One block with out_ready high; checks round walk, in_ready, latency and ciphertext.
    task automatic run_vec(input string name, input logic [127:0] pt, input logic [127:0] key,
                           input logic [127:0] exp, input bit churn);
        int n;
        @(negedge clk);
        chk({name, "_in_ready_idle"}, in_ready, 1);
        in_valid  = 1'b1;
        data_in   = pt;
        key_in    = key;
        out_ready = 1'b1;
        @(negedge clk);
        n = 1;
        while (!out_valid && n < 30) begin
            chk({name, "_round_num"}, dp_round_num, n);
            chk({name, "_dp_last"}, dp_last, n == 10);
            chk({name, "_in_ready_run"}, in_ready, 0);
            if (churn) begin
                in_valid = ($urandom % 2) == 1;
                data_in  = {$urandom, $urandom, $urandom, $urandom};
                key_in   = {$urandom, $urandom, $urandom, $urandom};
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        in_valid = 1'b0;
        chk({name, "_latency"}, n - 1, 10);
        chk({name, "_data_out"}, data_out, exp);
        @(negedge clk);
        chk({name, "_out_valid_after"}, out_valid, 0);
        chk({name, "_busy_after"}, busy, 0);
    endtask

    typedef struct {
        logic [127:0] pt;
        logic [127:0] key;
        logic [127:0] ct;
        bit           churn;
    } vec_t;

    vec_t vecs[8];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        int n;
        int t1;
        int t2;

        vecs[0] = '{PT_B, KEY_B, CT_B, 1'b0};
        vecs[1] = '{PT_C, KEY_C, CT_C, 1'b1};
        for (int i = 2; i < 8; i++) begin
            vecs[i].pt    = {$urandom, $urandom, $urandom, $urandom};
            vecs[i].key   = {$urandom, $urandom, $urandom, $urandom};
            vecs[i].ct    = ref_encrypt(vecs[i].pt, vecs[i].key);
            vecs[i].churn = (i % 2) == 1;
        end

        #3;
        chk("reset_in_ready", in_ready, 1);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_busy", busy, 0);
        chk("reset_data_out", data_out, 0);
        chk("reset_dp_last", dp_last, 0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) run_vec($sformatf("vec%0d", i), vecs[i].pt, vecs[i].key,
                                            vecs[i].ct, vecs[i].churn);

        // Back-pressure: result must hold while a second offer is refused.
        @(negedge clk);
        in_valid = 1'b1; data_in = PT_C; key_in = KEY_C; out_ready = 1'b0;
        @(negedge clk);
        data_in = PT_B; key_in = KEY_B;
        wait_valid(n);
        for (int i = 0; i < 5; i++) begin
            chk("bp_data_hold", data_out, CT_C);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_out_valid", out_valid, 1);
            @(negedge clk);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        chk("bp_out_valid_released", out_valid, 0);
        chk("bp_busy_released", busy, 0);
        chk("bp_in_ready_released", in_ready, 1);

        // Back-to-back: second block accepted on the edge the first one leaves.
        @(negedge clk);
        in_valid = 1'b1; data_in = PT_C; key_in = KEY_C; out_ready = 1'b1;
        @(negedge clk);
        chk("b2b_busy_first", busy, 1);
        data_in = PT_B; key_in = KEY_B;
        wait_valid(n);
        t1 = cyc;
        chk("b2b_first_data", data_out, CT_C);
        @(negedge clk);
        in_valid = 1'b0;
        chk("b2b_second_busy", busy, 1);
        chk("b2b_second_out_valid", out_valid, 0);
        wait_valid(n);
        t2 = cyc;
        chk("b2b_gap", t2 - t1, 11);
        chk("b2b_second_data", data_out, CT_B);
        @(negedge clk);
        chk("b2b_idle", out_valid, 0);

        // Asynchronous reset at round 5 aborts the block.
        @(negedge clk);
        in_valid = 1'b1; data_in = PT_B; key_in = KEY_B; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        n = 0;
        while (dp_round_num != 4'd5 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("rst_reached_round5", dp_round_num, 5);
        #2 rst = 1'b1;
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_data_out", data_out, 0);
        chk("rst_dp_last", dp_last, 0);
        chk("rst_round_num", dp_round_num, 0);
        @(negedge clk);
        rst = 1'b0;
        run_vec("after_rst", PT_B, KEY_B, CT_B, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
